// File: rtl/parser_layer_hs.sv
// One protocol layer of a chained header parser: field extraction, masked rule lookup,
// header strip and metadata merge behind a valid/ready pipeline, with a 32-bit config bus.
`timescale 1ns/1ps
module parser_layer_hs #(
  parameter int HEAD_W    = 512,
  parameter int META_W    = 256,
  parameter int TYPE_NUM  = 2,
  parameter int TYPE_W    = 16,
  parameter int KEY_NUM   = 4,
  parameter int KEY_W     = 16,
  parameter int RULE_NUM  = 8,
  parameter int TWO_CYCLE = 0,
  localparam int OFF_W    = $clog2(HEAD_W/8),
  localparam int SH_W     = OFF_W + 1,
  localparam int RIDX_W   = (RULE_NUM > 1) ? $clog2(RULE_NUM) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [HEAD_W-1:0]         i_head,
  input  logic [META_W-1:0]         i_meta,
  input  logic [TYPE_NUM*OFF_W-1:0] i_type_offset,
  input  logic [KEY_NUM*OFF_W-1:0]  i_key_offset,
  input  logic [KEY_NUM-1:0]        i_key_offset_v,
  input  logic [SH_W-1:0]           i_head_shift,
  input  logic [SH_W-1:0]           i_meta_shift,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [HEAD_W-1:0]         o_head,
  output logic [META_W-1:0]         o_meta,
  output logic [TYPE_NUM*OFF_W-1:0] o_type_offset,
  output logic [KEY_NUM*OFF_W-1:0]  o_key_offset,
  output logic [KEY_NUM-1:0]        o_key_offset_v,
  output logic [SH_W-1:0]           o_head_shift,
  output logic [SH_W-1:0]           o_meta_shift,
  output logic                      o_miss,
  output logic [RIDX_W-1:0]         o_rule_idx,
  input  logic                      i_rule_wren,
  input  logic                      i_rule_rden,
  input  logic [31:0]               i_rule_addr,
  input  logic [31:0]               i_rule_wdata,
  output logic                      o_rule_rvalid,
  output logic [31:0]               o_rule_rdata
);
  localparam int TT_W  = TYPE_NUM * TYPE_W;
  localparam int TO_W  = TYPE_NUM * OFF_W;
  localparam int KO_W  = KEY_NUM * OFF_W;
  localparam int EXT_W = KEY_NUM * KEY_W;
  localparam int EXT_B = EXT_W / 8;
  localparam int HIT_A = RULE_NUM * 8;

  // Appending W zero bits makes bytes past the header end read as 0.
  function automatic logic [TYPE_W-1:0] pick_type(input logic [HEAD_W-1:0] h, input logic [OFF_W-1:0] o);
    logic [HEAD_W+TYPE_W-1:0] w;
    w = {h, {TYPE_W{1'b0}}} << {o, 3'b000};
    return w[HEAD_W+TYPE_W-1 -: TYPE_W];
  endfunction

  function automatic logic [KEY_W-1:0] pick_key(input logic [HEAD_W-1:0] h, input logic [OFF_W-1:0] o);
    logic [HEAD_W+KEY_W-1:0] w;
    w = {h, {KEY_W{1'b0}}} << {o, 3'b000};
    return w[HEAD_W+KEY_W-1 -: KEY_W];
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  logic                adv;
  logic [TT_W-1:0]     type_c;
  logic [EXT_W-1:0]    ext_c;
  logic [SH_W-1:0]     ms_c;
  logic [META_W-1:0]   top_m, ext_al, meta_c;
  logic [HEAD_W-1:0]   head_c;

  assign adv     = ~o_valid | i_ready;
  assign o_ready = adv;

  always_comb begin
    type_c = '0;
    ext_c  = '0;
    for (int i = 0; i < TYPE_NUM; i++)
      type_c[i*TYPE_W +: TYPE_W] = pick_type(i_head, i_type_offset[i*OFF_W +: OFF_W]);
    for (int i = 0; i < KEY_NUM; i++)
      if (i_key_offset_v[i])
        ext_c[EXT_W-1-i*KEY_W -: KEY_W] = pick_key(i_head, i_key_offset[i*OFF_W +: OFF_W]);
    ms_c   = (i_meta_shift > SH_W'(EXT_B)) ? SH_W'(EXT_B) : i_meta_shift;
    top_m  = ~({META_W{1'b1}} >> {ms_c, 3'b000});
    ext_al = META_W'(ext_c) << (META_W - EXT_W);
    meta_c = ((i_meta >> {ms_c, 3'b000}) & ~top_m) | (ext_al & top_m);
    head_c = i_head << {i_head_shift, 3'b000};
  end

  // Stage p0: extracted fields, shifted header, merged metadata
  logic              vld_p0;
  logic [TT_W-1:0]   type_p0;
  logic [HEAD_W-1:0] head_p0;
  logic [META_W-1:0] meta_p0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p0  <= 1'b0;
      type_p0 <= '0;
      head_p0 <= '0;
      meta_p0 <= '0;
    end else if (adv) begin
      vld_p0  <= i_valid;
      type_p0 <= type_c;
      head_p0 <= head_c;
      meta_p0 <= meta_c;
    end
  end

  logic              lk_vld;
  logic [TT_W-1:0]   lk_type;
  logic [HEAD_W-1:0] lk_head;
  logic [META_W-1:0] lk_meta;

  generate
    if (TWO_CYCLE != 0) begin : g_p1
      // Stage p1: optional retiming register ahead of the lookup
      logic              vld_p1;
      logic [TT_W-1:0]   type_p1;
      logic [HEAD_W-1:0] head_p1;
      logic [META_W-1:0] meta_p1;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          vld_p1  <= 1'b0;
          type_p1 <= '0;
          head_p1 <= '0;
          meta_p1 <= '0;
        end else if (adv) begin
          vld_p1  <= vld_p0;
          type_p1 <= type_p0;
          head_p1 <= head_p0;
          meta_p1 <= meta_p0;
        end
      end
      assign lk_vld  = vld_p1;
      assign lk_type = type_p1;
      assign lk_head = head_p1;
      assign lk_meta = meta_p1;
    end else begin : g_p0
      assign lk_vld  = vld_p0;
      assign lk_type = type_p0;
      assign lk_head = head_p0;
      assign lk_meta = meta_p0;
    end
  endgenerate

  logic              rule_v   [RULE_NUM];
  logic [31:0]       rule_val [RULE_NUM];
  logic [31:0]       rule_msk [RULE_NUM];
  logic [TO_W-1:0]   rule_to  [RULE_NUM];
  logic [KO_W-1:0]   rule_ko  [RULE_NUM];
  logic [KEY_NUM-1:0] rule_kv [RULE_NUM];
  logic [SH_W-1:0]   rule_hs  [RULE_NUM];
  logic [SH_W-1:0]   rule_ms  [RULE_NUM];

  logic              rule_sel;
  logic [RIDX_W-1:0] cfg_r;
  logic [2:0]        cfg_w;

  assign rule_sel = i_rule_addr < 32'(HIT_A);
  assign cfg_r    = RIDX_W'(i_rule_addr >> 3);
  assign cfg_w    = i_rule_addr[2:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < RULE_NUM; r++) begin
        rule_v[r]   <= 1'b0;
        rule_val[r] <= '0;
        rule_msk[r] <= '0;
        rule_to[r]  <= '0;
        rule_ko[r]  <= '0;
        rule_kv[r]  <= '0;
        rule_hs[r]  <= '0;
        rule_ms[r]  <= '0;
      end
    end else if (i_rule_wren && rule_sel) begin
      case (cfg_w)
        3'd0: rule_v[cfg_r]   <= i_rule_wdata[0];
        3'd1: rule_val[cfg_r] <= i_rule_wdata;
        3'd2: rule_msk[cfg_r] <= i_rule_wdata;
        3'd3: rule_to[cfg_r]  <= i_rule_wdata[TO_W-1:0];
        3'd4: rule_ko[cfg_r]  <= i_rule_wdata[KO_W-1:0];
        3'd5: rule_kv[cfg_r]  <= i_rule_wdata[KEY_NUM-1:0];
        3'd6: begin
          rule_hs[cfg_r] <= i_rule_wdata[SH_W-1:0];
          rule_ms[cfg_r] <= i_rule_wdata[16 +: SH_W];
        end
        default: ;
      endcase
    end
  end

  // Descending scan so the lowest-index hit is the one left standing.
  logic              hit_c;
  logic [RIDX_W-1:0] idx_c;

  always_comb begin
    hit_c = 1'b0;
    idx_c = '0;
    for (int r = RULE_NUM - 1; r >= 0; r--) begin
      if (rule_v[r] && (((lk_type ^ rule_val[r][TT_W-1:0]) & rule_msk[r][TT_W-1:0]) == '0)) begin
        hit_c = 1'b1;
        idx_c = RIDX_W'(r);
      end
    end
  end

  // Output stage: lookup result registered with the beat
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid        <= 1'b0;
      o_head         <= '0;
      o_meta         <= '0;
      o_miss         <= 1'b0;
      o_rule_idx     <= '0;
      o_type_offset  <= '0;
      o_key_offset   <= '0;
      o_key_offset_v <= '0;
      o_head_shift   <= '0;
      o_meta_shift   <= '0;
    end else if (adv) begin
      o_valid        <= lk_vld;
      o_head         <= lk_head;
      o_meta         <= lk_meta;
      o_miss         <= ~hit_c;
      o_rule_idx     <= idx_c;
      o_type_offset  <= hit_c ? rule_to[idx_c] : '0;
      o_key_offset   <= hit_c ? rule_ko[idx_c] : '0;
      o_key_offset_v <= hit_c ? rule_kv[idx_c] : '0;
      o_head_shift   <= hit_c ? rule_hs[idx_c] : '0;
      o_meta_shift   <= hit_c ? rule_ms[idx_c] : '0;
    end
  end

  logic [31:0] hit_cnt, miss_cnt, rd_c;
  logic        out_hs;

  assign out_hs = o_valid & i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (i_rule_wren && i_rule_addr == 32'(HIT_A))
        hit_cnt <= '0;
      else if (out_hs && !o_miss)
        hit_cnt <= sat_inc(hit_cnt);
      if (i_rule_wren && i_rule_addr == 32'(HIT_A + 1))
        miss_cnt <= '0;
      else if (out_hs && o_miss)
        miss_cnt <= sat_inc(miss_cnt);
    end
  end

  always_comb begin
    rd_c = '0;
    if (rule_sel) begin
      case (cfg_w)
        3'd0: rd_c = {31'b0, rule_v[cfg_r]};
        3'd1: rd_c = rule_val[cfg_r];
        3'd2: rd_c = rule_msk[cfg_r];
        3'd3: rd_c = 32'(rule_to[cfg_r]);
        3'd4: rd_c = 32'(rule_ko[cfg_r]);
        3'd5: rd_c = 32'(rule_kv[cfg_r]);
        3'd6: begin
          rd_c[SH_W-1:0]  = rule_hs[cfg_r];
          rd_c[16 +: SH_W] = rule_ms[cfg_r];
        end
        default: ;
      endcase
    end else if (i_rule_addr == 32'(HIT_A)) begin
      rd_c = hit_cnt;
    end else if (i_rule_addr == 32'(HIT_A + 1)) begin
      rd_c = miss_cnt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rule_rvalid <= 1'b0;
      o_rule_rdata  <= '0;
    end else begin
      o_rule_rvalid <= i_rule_rden;
      if (i_rule_rden) o_rule_rdata <= rd_c;
    end
  end

endmodule
